// File: rtl/trap_shaper_mc.sv
// Time-multiplexed multi-channel trapezoidal shaper: per-channel delay line, 3-stage d/p/s pipeline.
// Optional output clamping is enabled by defining TRAP_SAT_EN.
module trap_shaper_mc #(
    parameter int NUM_CH = 4,
    parameter int IN_W   = 14,
    parameter int ACC_W  = 32,
    parameter int OUT_W  = 16,
    parameter int DEPTH  = 64,
    parameter int M_W    = 8,
    parameter int SHIFT  = 7,
    parameter int DEF_K  = 8,
    parameter int DEF_L  = 4,
    parameter int DEF_M  = 0,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CH_W-1:0]         in_ch,
    input  logic signed [IN_W-1:0]  in_data,
    input  logic                    cfg_load,
    input  logic [PTR_W-1:0]        cfg_k,
    input  logic [PTR_W-1:0]        cfg_l,
    input  logic [M_W-1:0]          cfg_m,
    output logic                    cfg_err,
    output logic                    out_valid,
    output logic [CH_W-1:0]         out_ch,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_sat
);

    typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, CLEAR = 2'd2} state_e;

    localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] OUT_MIN = -OUT_MAX - ACC_W'(1);

    function automatic logic signed [ACC_W-1:0] sext(input logic signed [IN_W-1:0] x);
        return {{(ACC_W - IN_W){x[IN_W-1]}}, x};
    endfunction

    state_e                   state_q, state_d;
    logic [1:0]               cnt_q, cnt_d;
    logic                     clear_s, in_ready_q;
    logic [PTR_W-1:0]         k_q, l_q, pk_q, pl_q;
    logic [M_W-1:0]           m_q, pm_q;
    logic                     cfg_err_q;
    logic [PTR_W:0]           kl_sum_s;
    logic                     cfg_legal_s, load_ok_s, accept_s, ch_ok_s;

    logic signed [IN_W-1:0]   dl_q [NUM_CH][DEPTH];
    logic [PTR_W-1:0]         wp_q [NUM_CH];
    logic [PTR_W-1:0]         wp_s, idx_l_s, idx_k_s, idx_kl_s;
    logic signed [ACC_W-1:0]  d_s;

    logic                     v1_q, v2_q;
    logic [CH_W-1:0]          ch1_q, ch2_q;
    logic signed [ACC_W-1:0]  d1_q, r2_q;
    logic signed [ACC_W-1:0]  p_q [NUM_CH];
    logic signed [ACC_W-1:0]  s_q [NUM_CH];
    logic signed [ACC_W-1:0]  p_new_s, r_s, s_new_s, sh_s;
    logic signed [OUT_W-1:0]  out_d_s;
    logic                     sat_d_s;

    logic                     out_valid_q, out_sat_q;
    logic [CH_W-1:0]          out_ch_q;
    logic signed [OUT_W-1:0]  out_data_q;

    assign kl_sum_s    = {1'b0, cfg_k} + {1'b0, cfg_l};
    assign cfg_legal_s = (cfg_l != '0) && (cfg_l <= cfg_k) && (kl_sum_s <= (PTR_W + 1)'(DEPTH - 1));
    // A legal load takes priority over a sample offered in the same cycle.
    assign load_ok_s   = (state_q == RUN) && cfg_load && cfg_legal_s;
    assign accept_s    = in_valid && (state_q == RUN) && !load_ok_s;

    generate
        if (NUM_CH == (1 << CH_W)) begin : g_ch_full
            assign ch_ok_s = 1'b1;
        end else begin : g_ch_part
            assign ch_ok_s = ({1'b0, in_ch} < (CH_W + 1)'(NUM_CH));
        end
    endgenerate

    // Next-state logic for the reconfiguration sequencer
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clear_s = 1'b0;
        case (state_q)
            RUN: begin
                if (load_ok_s) begin
                    state_d = FLUSH;
                    cnt_d   = 2'd0;
                end else begin
                    state_d = RUN;
                end
            end
            FLUSH: begin
                if (cnt_q == 2'd2) begin
                    state_d = CLEAR;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            CLEAR: begin
                clear_s = 1'b1;
                state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // Sequencer state, ready flag and configuration registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            cnt_q      <= 2'd0;
            in_ready_q <= 1'b1;
            k_q        <= PTR_W'(DEF_K);
            l_q        <= PTR_W'(DEF_L);
            m_q        <= M_W'(DEF_M);
            pk_q       <= PTR_W'(DEF_K);
            pl_q       <= PTR_W'(DEF_L);
            pm_q       <= M_W'(DEF_M);
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            in_ready_q <= (state_d == RUN);
            if (cfg_load && (state_q == RUN)) begin
                if (cfg_legal_s) begin
                    pk_q      <= cfg_k;
                    pl_q      <= cfg_l;
                    pm_q      <= cfg_m;
                    cfg_err_q <= 1'b0;
                end else begin
                    cfg_err_q <= 1'b1;
                end
            end
            if (clear_s) begin
                k_q <= pk_q;
                l_q <= pl_q;
                m_q <= pm_q;
            end
        end
    end

    // Stage 1: the write slot wp is never one of the three taps since k+l < DEPTH
    always_comb begin
        wp_s     = wp_q[in_ch];
        idx_l_s  = wp_s - l_q;
        idx_k_s  = wp_s - k_q;
        idx_kl_s = wp_s - k_q - l_q;
        d_s      = sext(in_data) - sext(dl_q[in_ch][idx_l_s])
                 - sext(dl_q[in_ch][idx_k_s]) + sext(dl_q[in_ch][idx_kl_s]);
    end

    // Delay lines, write pointers and stage-1 registers
    always_ff @(posedge clk) begin
        if (reset || clear_s) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wp_q[c] <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    dl_q[c][i] <= '0;
                end
            end
        end else if (accept_s && ch_ok_s) begin
            dl_q[in_ch][wp_s] <= in_data;
            wp_q[in_ch]       <= wp_s + PTR_W'(1);
        end
        if (reset) begin
            v1_q  <= 1'b0;
            ch1_q <= '0;
            d1_q  <= '0;
        end else begin
            v1_q  <= accept_s && ch_ok_s;
            ch1_q <= in_ch;
            d1_q  <= d_s;
        end
    end

    assign p_new_s = p_q[ch1_q] + d1_q;
    assign r_s     = p_new_s + ($signed({{(ACC_W - M_W){1'b0}}, m_q}) * d1_q);
    assign s_new_s = s_q[ch2_q] + r2_q;
    assign sh_s    = s_new_s >>> SHIFT;

    // Output formatting: clamp or wrap
    always_comb begin
        out_d_s = '0;
        sat_d_s = 1'b0;
`ifdef TRAP_SAT_EN
        if (sh_s > OUT_MAX) begin
            out_d_s = OUT_W'(OUT_MAX);
            sat_d_s = 1'b1;
        end else if (sh_s < OUT_MIN) begin
            out_d_s = OUT_W'(OUT_MIN);
            sat_d_s = 1'b1;
        end else begin
            out_d_s = OUT_W'(sh_s);
        end
`else
        out_d_s = OUT_W'(sh_s);
        sat_d_s = 1'b0;
`endif
    end

    // Stages 2 and 3: per-channel p and s accumulators and output registers
    always_ff @(posedge clk) begin
        if (reset || clear_s) begin
            for (int c = 0; c < NUM_CH; c++) begin
                p_q[c] <= '0;
                s_q[c] <= '0;
            end
        end else begin
            if (v1_q) begin
                p_q[ch1_q] <= p_new_s;
            end
            if (v2_q) begin
                s_q[ch2_q] <= s_new_s;
            end
        end
        if (reset) begin
            v2_q        <= 1'b0;
            ch2_q       <= '0;
            r2_q        <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            v2_q        <= v1_q;
            ch2_q       <= ch1_q;
            r2_q        <= r_s;
            out_valid_q <= v2_q;
            out_ch_q    <= v2_q ? ch2_q : '0;
            out_data_q  <= v2_q ? out_d_s : '0;
            out_sat_q   <= v2_q && sat_d_s;
        end
    end

    assign in_ready  = in_ready_q;
    assign cfg_err   = cfg_err_q;
    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

endmodule
